inorder_slot_commit: RTL and testbench

Allocates slot indices in FIFO order and releases them in order once their completion bits are set in the slot valid bitvector. It sits directly downstream of the valid bitvector: completions set bits out of order, this block watches the bit at the head slot, emits that slot as committed, and drives the clear port back into the bitvector. It is the in-order retirement point for any out-of-order completion engine built on a slot bitvector.

---
 rtl/inorder_slot_commit_if.sv | 31 +++
 rtl/inorder_slot_commit.sv | 65 ++++++
 tb/tb_inorder_slot_commit.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inorder_slot_commit_if.sv
// Handshake bundle between the in-order commit block, its allocator, the slot
// valid bitvector and the commit consumer.
interface inorder_slot_commit_if #(
    parameter int NUM_SLOTS    = 64,
    parameter int SLOT_INDEX_W = $clog2(NUM_SLOTS)
);
    logic                    alloc_val;
    logic                    alloc_rdy;
    logic [SLOT_INDEX_W-1:0] alloc_index;
    logic [NUM_SLOTS-1:0]    valid_bitvector;
    logic                    clear_val;
    logic [SLOT_INDEX_W-1:0] clear_index;
    logic                    commit_val;
    logic [SLOT_INDEX_W-1:0] commit_index;
    logic                    commit_rdy;
    logic [SLOT_INDEX_W:0]   occupancy;

    // Environment side: requester, bitvector and commit consumer.
    modport master (
        output alloc_val, valid_bitvector, commit_rdy,
        input  alloc_rdy, alloc_index, clear_val, clear_index,
               commit_val, commit_index, occupancy
    );

    // Commit block side.
    modport slave (
        input  alloc_val, valid_bitvector, commit_rdy,
        output alloc_rdy, alloc_index, clear_val, clear_index,
               commit_val, commit_index, occupancy
    );
endinterface

// File: rtl/inorder_slot_commit.sv
// FIFO slot allocator that retires slots in order once their completion bit
// is set, clearing the bit back into the bitvector as the slot is committed.
module inorder_slot_commit #(
    parameter int NUM_SLOTS    = 64,
    parameter int SLOT_INDEX_W = $clog2(NUM_SLOTS)
) (
    input logic                  clk,
    input logic                  rst,
    inorder_slot_commit_if.slave bus
);
    localparam logic [SLOT_INDEX_W:0] FULL = (SLOT_INDEX_W+1)'(NUM_SLOTS);

    logic [SLOT_INDEX_W-1:0] head_ptr;
    logic [SLOT_INDEX_W-1:0] tail_ptr;
    logic [SLOT_INDEX_W:0]   occupancy;
    logic                    commit_val;
    logic [SLOT_INDEX_W-1:0] commit_index;

    logic alloc_fire;
    logic load;

    assign bus.alloc_rdy   = (occupancy != FULL);
    assign bus.alloc_index = tail_ptr;
    assign alloc_fire      = bus.alloc_val && bus.alloc_rdy;

    // Empty check keeps a stray bit at head from committing an unallocated slot.
    assign load = (occupancy != '0) && bus.valid_bitvector[head_ptr] &&
                  (!commit_val || bus.commit_rdy);

    // Clear is suppressed during reset: the bitvector is wiped by the same rst.
    assign bus.clear_val   = load && !rst;
    assign bus.clear_index = head_ptr;

    assign bus.commit_val   = commit_val;
    assign bus.commit_index = commit_index;
    assign bus.occupancy    = occupancy;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr     <= '0;
            tail_ptr     <= '0;
            occupancy    <= '0;
            commit_val   <= 1'b0;
            commit_index <= '0;
        end else begin
            // Pointers wrap naturally since NUM_SLOTS is a power of two.
            if (alloc_fire)
                tail_ptr <= tail_ptr + 1'b1;

            if (load) begin
                commit_val   <= 1'b1;
                commit_index <= head_ptr;
                head_ptr     <= head_ptr + 1'b1;
            end else if (commit_val && bus.commit_rdy) begin
                commit_val <= 1'b0;
            end

            case ({alloc_fire, load})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end
endmodule

// File: tb/tb_inorder_slot_commit.sv
// Directed bench for inorder_slot_commit with a registered bitvector model that
// takes set requests from the stimulus and clears from the DUT.
module tb_inorder_slot_commit;
    localparam int N = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] set_req = '0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inorder_slot_commit_if #(.NUM_SLOTS(N)) bus();

    inorder_slot_commit #(.NUM_SLOTS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Bitvector: sets land one cycle after request, clears on the DUT's pulse.
    always @(posedge clk) begin
        if (rst)
            bus.valid_bitvector <= '0;
        else
            bus.valid_bitvector <= (bus.valid_bitvector | set_req) &
                ~(bus.clear_val ? (N'(1) << bus.clear_index) : N'(0));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_alloc_rdy"},    64'(bus.alloc_rdy),    1);
        chk({tag, "_alloc_index"},  64'(bus.alloc_index),  0);
        chk({tag, "_occupancy"},    64'(bus.occupancy),    0);
        chk({tag, "_commit_val"},   64'(bus.commit_val),   0);
        chk({tag, "_commit_index"}, 64'(bus.commit_index), 0);
        chk({tag, "_clear_val"},    64'(bus.clear_val),    0);
        chk({tag, "_clear_index"},  64'(bus.clear_index),  0);
    endtask

    initial begin
        bus.alloc_val  = 1'b0;
        bus.commit_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_reset_state("reset");

        // Three allocs, then completions out of order -> burst commit 0,1,2.
        bus.alloc_val = 1'b1;
        #1 chk("t1_alloc0", 64'(bus.alloc_index), 0);
        tick();
        #1 chk("t1_alloc1", 64'(bus.alloc_index), 1);
        tick();
        #1 chk("t1_alloc2", 64'(bus.alloc_index), 2);
        tick();
        bus.alloc_val  = 1'b0;
        bus.commit_rdy = 1'b1;
        #1 chk("t1_occ3", 64'(bus.occupancy), 3);
        set_req = N'(4);
        tick();
        set_req = N'(2);
        tick();
        set_req = N'(1);
        #1 chk("t1_no_clear_yet", 64'(bus.clear_val), 0);
        tick();
        set_req = '0;
        #1;
        chk("t1_clear0_val", 64'(bus.clear_val), 1);
        chk("t1_clear0_idx", 64'(bus.clear_index), 0);
        chk("t1_commit_not_yet", 64'(bus.commit_val), 0);
        tick();
        #1;
        chk("t1_commit0_val", 64'(bus.commit_val), 1);
        chk("t1_commit0_idx", 64'(bus.commit_index), 0);
        chk("t1_clear1_idx", 64'(bus.clear_index), 1);
        chk("t1_clear1_val", 64'(bus.clear_val), 1);
        tick();
        #1;
        chk("t1_commit1_idx", 64'(bus.commit_index), 1);
        chk("t1_clear2_idx", 64'(bus.clear_index), 2);
        tick();
        #1;
        chk("t1_commit2_idx", 64'(bus.commit_index), 2);
        chk("t1_clear_done", 64'(bus.clear_val), 0);
        chk("t1_occ0", 64'(bus.occupancy), 0);
        tick();
        #1 chk("t1_commit_drop", 64'(bus.commit_val), 0);

        // Ten outstanding (slots 3..12), then alloc and load in one cycle.
        bus.alloc_val = 1'b1;
        repeat (10) tick();
        bus.alloc_val = 1'b0;
        set_req = N'(1) << 3;
        #1;
        chk("t4_occ10", 64'(bus.occupancy), 10);
        chk("t4_tail13", 64'(bus.alloc_index), 13);
        tick();
        set_req = '0;
        bus.alloc_val = 1'b1;
        #1;
        chk("t4_alloc_idx", 64'(bus.alloc_index), 13);
        chk("t4_clear_val", 64'(bus.clear_val), 1);
        chk("t4_clear_idx", 64'(bus.clear_index), 3);
        tick();
        bus.alloc_val = 1'b0;
        #1;
        chk("t4_occ_same", 64'(bus.occupancy), 10);
        chk("t4_commit_idx", 64'(bus.commit_index), 3);
        chk("t4_tail_adv", 64'(bus.alloc_index), 14);
        chk("t4_head_adv", 64'(bus.clear_index), 4);
        set_req = N'(64'h3FF0);
        tick();
        set_req = '0;
        repeat (14) tick();
        #1;
        chk("t4_drain_occ", 64'(bus.occupancy), 0);
        chk("t4_drain_cv", 64'(bus.commit_val), 0);
        chk("t4_drain_head", 64'(bus.clear_index), 14);

        // Back-pressure: slot 14 held for 5 cycles, slot 15 follows handshake.
        bus.commit_rdy = 1'b0;
        bus.alloc_val  = 1'b1;
        tick();
        tick();
        bus.alloc_val = 1'b0;
        set_req = N'(1) << 14;
        #1 chk("t3_occ2", 64'(bus.occupancy), 2);
        tick();
        set_req = N'(1) << 15;
        #1;
        chk("t3_clear_val", 64'(bus.clear_val), 1);
        chk("t3_clear_idx", 64'(bus.clear_index), 14);
        tick();
        set_req = '0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t3_hold_val", 64'(bus.commit_val), 1);
            chk("t3_hold_idx", 64'(bus.commit_index), 14);
            chk("t3_hold_noclear", 64'(bus.clear_val), 0);
            tick();
        end
        bus.commit_rdy = 1'b1;
        #1;
        chk("t3_hs_clear_val", 64'(bus.clear_val), 1);
        chk("t3_hs_clear_idx", 64'(bus.clear_index), 15);
        chk("t3_hs_commit_idx", 64'(bus.commit_index), 14);
        tick();
        #1;
        chk("t3_next_idx", 64'(bus.commit_index), 15);
        chk("t3_next_noclear", 64'(bus.clear_val), 0);
        chk("t3_occ0", 64'(bus.occupancy), 0);
        tick();
        #1 chk("t3_commit_drop", 64'(bus.commit_val), 0);

        // Stray bits with nothing allocated: at head (16) and at slot 7.
        set_req = (N'(1) << 16) | (N'(1) << 7);
        tick();
        set_req = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_no_clear", 64'(bus.clear_val), 0);
            chk("t5_no_commit", 64'(bus.commit_val), 0);
            tick();
        end
        #1 chk("t5_occ0", 64'(bus.occupancy), 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_reset_state("rst2");

        // Fill all 64 slots, then retire slot 0 and see alloc wrap to 0.
        bus.alloc_val = 1'b1;
        repeat (63) tick();
        #1;
        chk("t2_alloc63", 64'(bus.alloc_index), 63);
        chk("t2_rdy_before_full", 64'(bus.alloc_rdy), 1);
        tick();
        bus.alloc_val = 1'b0;
        #1;
        chk("t2_occ64", 64'(bus.occupancy), 64);
        chk("t2_full_rdy", 64'(bus.alloc_rdy), 0);
        chk("t2_full_tail", 64'(bus.alloc_index), 0);
        set_req = N'(1);
        tick();
        set_req = '0;
        #1;
        chk("t2_load_clear", 64'(bus.clear_val), 1);
        chk("t2_load_idx", 64'(bus.clear_index), 0);
        chk("t2_load_rdy", 64'(bus.alloc_rdy), 0);
        tick();
        #1;
        chk("t2_rdy_back", 64'(bus.alloc_rdy), 1);
        chk("t2_wrap_idx", 64'(bus.alloc_index), 0);
        chk("t2_occ63", 64'(bus.occupancy), 63);
        chk("t2_commit0", 64'(bus.commit_index), 0);
        chk("t2_commit_val", 64'(bus.commit_val), 1);

        // Reset with 5 outstanding slots and a commit stalled at the output.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.alloc_val  = 1'b1;
        bus.commit_rdy = 1'b0;
        repeat (6) tick();
        bus.alloc_val = 1'b0;
        set_req = N'(1);
        tick();
        set_req = '0;
        tick();
        #1;
        chk("t6_pre_cv", 64'(bus.commit_val), 1);
        chk("t6_pre_occ", 64'(bus.occupancy), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk_reset_state("t6_rst");
        bus.alloc_val = 1'b1;
        #1 chk("t6_first_alloc", 64'(bus.alloc_index), 0);
        tick();
        bus.alloc_val = 1'b0;
        #1 chk("t6_occ1", 64'(bus.occupancy), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
